core_div_seq: RTL and testbench
===============================

# core_div_seq

Multi-cycle sequencer for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU) in the execute stage. It accepts one operand pair through a valid/ready handshake and runs a 32-iteration restoring division on magnitudes, then applies a sign fixup. The result is held under a valid/ready handshake until the writeback side takes it. The exec stage stalls on `busy` while a divide is in flight; single-cycle ALU ops bypass this block.

## Interface
- Parameters: none; operand width is fixed at 32.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  operand pair and op are valid this cycle.
- `req_ready`  out  1  block can accept a request (state IDLE).
- `div_op`  in  `core_pkg::div_op_e`  one of DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU.
- `dividend`  in  32  rs1 value.
- `divisor`  in  32  rs2 value.
- `flush`  in  1  abort any in-flight operation (pipeline kill).
- `resp_valid`  out  1  `resp_value` is valid.
- `resp_ready`  in  1  consumer takes the result this cycle.
- `resp_value`  out  32  quotient or remainder, selected by the latched op.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States (`div_state_e`): IDLE, CALC, FIXUP, DONE.
- **IDLE**
  - Accept when `req_valid && req_ready`.
  - At accept, latch: op; signed flag (DIV/REM); `neg_q` = signed and the operand sign bits differ; `neg_r` = signed and `dividend[31]`; absolute values of both operands.
- **Special cases at accept** (go directly to DONE; skip CALC and FIXUP):
  - Divisor == 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- **CALC** (32 cycles; 5-bit counter loads 31, decrements to 0)
  - Per cycle: `shifted = {rem[31:0], quot[31]}` (33 bits); `diff = shifted - {1'b0, div_abs}`.
  - If `diff[32]==0`: rem ← diff, quot ← {quot[30:0], 1}.
  - Else: rem ← shifted, quot ← {quot[30:0], 0}.
  - `quot` is initialised with the dividend magnitude; `rem` is initialised to 0.
  - When counter == 0, go to FIXUP.
- **FIXUP**: quot ← `neg_q` ? −quot : quot; rem ← `neg_r` ? −rem[31:0] : rem[31:0]; go to DONE. All arithmetic is modulo 2^32.
- **DONE**
  - `resp_valid`=1; `resp_value` = quot for DIV/DIVU, rem for REM/REMU.
  - On `resp_ready`, go to IDLE.
  - The result stays stable while `resp_ready` is low.
- **`flush`**: highest priority in every state; next state is IDLE and `resp_valid` drops next cycle. A request presented in the same cycle as `flush` is not accepted.
- **Reset**: asynchronous; clears everything at any point, including mid-CALC. No partial result is ever emitted after reset.

## Timing
- Reset values:
  - state = IDLE
  - `req_ready`=1, `busy`=0, `resp_valid`=0
  - `resp_value`=0, counter=0, all datapath registers 0
- Normal latency: accept in cycle T; CALC covers T+1..T+32; FIXUP at T+33; `resp_valid` high from T+34.
- Special-case latency: `resp_valid` high at T+1.
- Throughput:
  - `req_ready` is low from T+1 until the cycle after the response handshake.
  - Accept and respond never overlap, so the minimum gap between accepts is 35 cycles.
- All outputs are registered or decoded directly from state; there is no combinational path from `req_valid` or `resp_ready` to any output.

## Structure
- `core_pkg` gains `div_op_e` (2-bit) and `div_state_e`; the decoder drives `div_op`.
- Sub-module `core_div_step`: combinational single-iteration step, taking {rem, quot, div_abs} and producing {rem_next, quot_next}. It keeps the FSM file focused on sequencing.

## Test plan
- DIVU 100 / 7: accept at T → `resp_valid` at T+34 with 14. REMU with the same operands → 2.
- REM −7 (0xFFFFFFF9) % 2 → 0xFFFFFFFF. DIV with the same operands → 0xFFFFFFFD (−3).
- DIV 5 / 0 → 0xFFFFFFFF at T+1. REM 5 / 0 → 5. `busy` is high for exactly one cycle.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1. REM with the same operands → 0.
- Hold `resp_ready` low 5 cycles after `resp_valid`: value and valid stay stable. After the handshake, `req_ready`=1 the next cycle.
- Flush at T+10 → `busy`=0 and `req_ready`=1 at T+11, and no `resp_valid` follows. Repeat with `rst_n` pulsed low at T+10: all outputs take reset values immediately.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types for the execute-stage divide sequencer
//
// Purpose: op and state enums for core_div_seq, plus a magnitude helper.
// Ports: none (package).

package core_pkg;

   typedef enum logic [1:0] {
      DIV_DIV  = 2'd0,
      DIV_DIVU = 2'd1,
      DIV_REM  = 2'd2,
      DIV_REMU = 2'd3
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } div_state_e;

   localparam logic [4:0] DIV_LAST_ITER = 5'd31;

   // Two's-complement magnitude; 0x80000000 maps to itself, which is the
   // correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] x);
      return x[31] ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/core_div_step.sv
// rtl/core_div_step.sv - one combinational restoring-division iteration
//
// Purpose: shifts the next dividend bit into the partial remainder and
//          conditionally subtracts the divisor magnitude.
// Ports:
//   rem_i      in  32  partial remainder
//   quot_i     in  32  quotient / remaining dividend bits
//   div_abs_i  in  32  divisor magnitude
//   rem_o      out 32  next partial remainder
//   quot_o     out 32  next quotient / dividend bits

module core_div_step (
   input  logic [31:0] rem_i,
   input  logic [31:0] quot_i,
   input  logic [31:0] div_abs_i,
   output logic [31:0] rem_o,
   output logic [31:0] quot_o
);

   logic [32:0] shifted;
   logic [32:0] diff;

   always_comb begin
      shifted = {rem_i, quot_i[31]};
      diff    = shifted - {1'b0, div_abs_i};
      // rem stays below div_abs, so the kept value always fits in 32 bits.
      if (!diff[32]) begin
         rem_o  = diff[31:0];
         quot_o = {quot_i[30:0], 1'b1};
      end else begin
         rem_o  = shifted[31:0];
         quot_o = {quot_i[30:0], 1'b0};
      end
   end

endmodule

// File: rtl/core_div_seq.sv
// rtl/core_div_seq.sv - multi-cycle RV32M DIV/DIVU/REM/REMU sequencer
//
// Purpose: accepts one operand pair, runs 32 restoring iterations on
//          magnitudes, applies the sign fixup and holds the result until
//          the writeback side takes it.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   div_op                DIV, DIVU, REM or REMU
//   dividend, divisor     rs1 / rs2 operands
//   flush                 abort any in-flight operation
//   resp_valid/resp_ready response handshake
//   resp_value            quotient or remainder per latched op
//   busy                  high whenever not IDLE

module core_div_seq
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  div_op_e     div_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        flush,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_value,
   output logic        busy
);

   div_state_e  state_q, state_d;
   div_op_e     op_q, op_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        quot_neg_q, quot_neg_d;
   logic        rem_neg_q, rem_neg_d;
   logic [31:0] quot_q, quot_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] div_abs_q, div_abs_d;

   logic [31:0] step_rem, step_quot;
   logic        is_signed;

   core_div_step u_step (
      .rem_i     (rem_q),
      .quot_i    (quot_q),
      .div_abs_i (div_abs_q),
      .rem_o     (step_rem),
      .quot_o    (step_quot)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      quot_neg_d = quot_neg_q;
      rem_neg_d  = rem_neg_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      div_abs_d  = div_abs_q;
      is_signed  = (div_op == DIV_DIV) || (div_op == DIV_REM);

      unique case (state_q)
         IDLE: begin
            if (req_valid && !flush) begin
               op_d       = div_op;
               quot_neg_d = is_signed && (dividend[31] ^ divisor[31]);
               rem_neg_d  = is_signed && dividend[31];
               div_abs_d  = is_signed ? abs32(divisor) : divisor;
               if (divisor == 32'd0) begin
                  quot_d  = 32'hFFFF_FFFF;
                  rem_d   = dividend;
                  state_d = DONE;
               end else if (is_signed && dividend == 32'h8000_0000 &&
                            divisor == 32'hFFFF_FFFF) begin
                  quot_d  = 32'h8000_0000;
                  rem_d   = 32'd0;
                  state_d = DONE;
               end else begin
                  quot_d  = is_signed ? abs32(dividend) : dividend;
                  rem_d   = 32'd0;
                  cnt_d   = DIV_LAST_ITER;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d  = step_rem;
            quot_d = step_quot;
            if (cnt_q == 5'd0) begin
               state_d = FIXUP;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         FIXUP: begin
            quot_d  = quot_neg_q ? (32'd0 - quot_q) : quot_q;
            rem_d   = rem_neg_q ? (32'd0 - rem_q) : rem_q;
            state_d = DONE;
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
      endcase

      if (flush) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_q       <= DIV_DIV;
         cnt_q      <= 5'd0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         quot_q     <= 32'd0;
         rem_q      <= 32'd0;
         div_abs_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         quot_neg_q <= quot_neg_d;
         rem_neg_q  <= rem_neg_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         div_abs_q  <= div_abs_d;
      end
   end

   // Outputs decode only registered state, never req_valid/resp_ready.
   assign req_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign resp_valid = (state_q == DONE);
   assign resp_value = (op_q == DIV_DIV || op_q == DIV_DIVU) ? quot_q : rem_q;

endmodule

// File: tb/tb_core_div_seq.sv
// tb/tb_core_div_seq.sv - directed and random checks for core_div_seq

module tb_core_div_seq;
   import core_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   div_op_e     div_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_value;
   logic        busy;

   core_div_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .div_op     (div_op),
      .dividend   (dividend),
      .divisor    (divisor),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_value (resp_value),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] sb[$];
   int n_vec = 0;
   int n_chk = 0;
   int n_err = 0;
   int t_acc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input div_op_e op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic sgn;
      logic [31:0] r;
      sgn = (op == DIV_DIV) || (op == DIV_REM);
      if (b == 32'd0)
         r = (op == DIV_DIV || op == DIV_DIVU) ? 32'hFFFF_FFFF : a;
      else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         r = (op == DIV_DIV) ? 32'h8000_0000 : 32'd0;
      else if (sgn)
         r = (op == DIV_DIV) ? $signed(a) / $signed(b) : $signed(a) % $signed(b);
      else
         r = (op == DIV_DIVU) ? a / b : a % b;
      return r;
   endfunction

   task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] exp);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      div_op    = op;
      dividend  = a;
      divisor   = b;
      n = 0;
      while (!req_ready && n < 80) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("accept_timeout", {31'd0, req_ready}, 32'd1);
      t_acc = cyc;
      n_vec++;
      if (push) sb.push_back(exp);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic get_resp(input string tag, input int lat, input int hold);
      int n;
      logic [31:0] exp;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 80);
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      if (!resp_valid) begin
         check({tag, "_timeout"}, {31'd0, resp_valid}, 32'd1);
         return;
      end
      check({tag, "_latency"}, cyc - t_acc, lat);
      check({tag, "_value"}, resp_value, exp);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
         check({tag, "_hold_value"}, resp_value, exp);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic expect_no_resp(input string tag, input int ncyc);
      int seen;
      seen = 0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      check({tag, "_no_resp"}, seen, 32'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      div_op_e     op;
      bit          sgn;
      int          lat;

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      div_op     = DIV_DIV;
      dividend   = 32'd0;
      divisor    = 32'd0;
      flush      = 1'b0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_value", resp_value, 32'd0);
      rst_n = 1'b1;

      issue(DIV_DIVU, 32'd100, 32'd7, 1'b1, 32'd14);
      get_resp("divu_100_7", 34, 0);
      issue(DIV_REMU, 32'd100, 32'd7, 1'b1, 32'd2);
      get_resp("remu_100_7_hold", 34, 5);
      issue(DIV_REM, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);
      get_resp("rem_m7_2", 34, 0);
      issue(DIV_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);
      get_resp("div_m7_2", 34, 0);
      issue(DIV_DIV, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF);
      get_resp("div_5_0", 1, 0);
      issue(DIV_REM, 32'd5, 32'd0, 1'b1, 32'd5);
      get_resp("rem_5_0", 1, 0);
      issue(DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
      get_resp("div_ovf", 1, 0);
      issue(DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0);
      get_resp("rem_ovf", 1, 0);
      issue(DIV_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF);
      get_resp("divu_max_1", 34, 0);

      // Flush in the middle of CALC.
      issue(DIV_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_req_ready", {31'd0, req_ready}, 32'd1);
      expect_no_resp("flush", 40);

      // Reset in the middle of CALC.
      issue(DIV_DIV, 32'd12345, 32'd11, 1'b0, 32'd0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_req_ready", {31'd0, req_ready}, 32'd1);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("arst_resp_value", resp_value, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_no_resp("arst", 40);

      for (int i = 0; i < 8; i++) begin
         a   = $urandom;
         b   = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         op  = div_op_e'($urandom_range(0, 3));
         sgn = (op == DIV_DIV) || (op == DIV_REM);
         lat = (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
         issue(op, a, b, 1'b1, model(op, a, b));
         get_resp("random", lat, i % 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
